// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg: shared UART byte width and TX sequencer state encodings.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int TX_ST_W     = 2;

  typedef enum logic [TX_ST_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ------------------------------------------------------------------
// uart_rr_pick: first valid requester at or after i_ptr, as one-hot + index.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant_next,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  int w_slot;

  always_comb begin
    o_grant_next = '0;
    o_grant_idx  = '0;
    o_any        = 1'b0;
    w_slot       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Walk ptr, ptr+1, ... wrapping without a modulo operator.
      w_slot = int'(i_ptr) + k;
      if (w_slot >= NUM_REQ) begin
        w_slot = w_slot - NUM_REQ;
      end
      if (!o_any && i_req_valid[IDX_W'(w_slot)]) begin
        o_any                        = 1'b1;
        o_grant_idx                  = IDX_W'(w_slot);
        o_grant_next[IDX_W'(w_slot)] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ------------------------------------------------------------------
// uart_tx_arbiter: packet-granular round-robin sharing of one UART TX.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int LEN_W       = 8,
  parameter int STARTUP_CYC = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_en,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]       i_req_len,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_busy,
  output logic                           o_tx_start,
  output logic [UART_BYTE_W-1:0]         o_tx_data,
  input  logic                           i_tx_busy,
  output logic                           o_tx_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SU_W  = $clog2(STARTUP_CYC + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [SU_W-1:0]  SU_MAX   = SU_W'(STARTUP_CYC);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  tx_state_e               r_state;
  tx_state_e               w_state_next;
  logic [NUM_REQ-1:0]      r_grant;
  logic [IDX_W-1:0]        r_gidx;
  logic [IDX_W-1:0]        r_ptr;
  logic [LEN_W-1:0]        r_count;
  logic [UART_BYTE_W-1:0]  r_tx_data;
  logic [SU_W-1:0]         r_su_cnt;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_tx_err;

  logic [NUM_REQ-1:0]      w_pick_grant;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_pick_any;
  logic [LEN_W-1:0]        w_pick_len;
  logic [UART_BYTE_W-1:0]  w_pick_data;
  logic [UART_BYTE_W-1:0]  w_cur_data;
  logic                    w_cur_valid;
  logic [IDX_W-1:0]        w_ptr_next;
  logic                    w_started;
  logic                    w_launch;
  logic                    w_ack_to;
  logic                    w_byte_done;
  logic                    w_release;
  logic                    w_next_byte;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req_valid  (i_req_valid),
    .i_ptr        (r_ptr),
    .o_grant_next (w_pick_grant),
    .o_grant_idx  (w_pick_idx),
    .o_any        (w_pick_any)
  );

  assign w_pick_len  = i_req_len[int'(w_pick_idx)*LEN_W +: LEN_W];
  assign w_pick_data = i_req_data[int'(w_pick_idx)*UART_BYTE_W +: UART_BYTE_W];
  assign w_cur_data  = i_req_data[int'(r_gidx)*UART_BYTE_W +: UART_BYTE_W];
  assign w_cur_valid = i_req_valid[r_gidx];
  assign w_ptr_next  = (r_gidx == IDX_LAST) ? '0 : r_gidx + IDX_W'(1);

  assign w_started   = (r_su_cnt == SU_MAX);
  // A frame still shifting out from before blocks the launch as well.
  assign w_launch    = (r_state == ST_IDLE) && w_started && i_en && w_pick_any && !i_tx_busy;
  assign w_ack_to    = (r_state == ST_WAIT_ACK) && !i_tx_busy && (r_to_cnt == TO_LAST);
  assign w_byte_done = (r_state == ST_WAIT_DONE) && !i_tx_busy;
  assign w_release   = (w_byte_done && ((r_count == '0) || !w_cur_valid)) || w_ack_to;
  assign w_next_byte = w_byte_done && (r_count != '0) && w_cur_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        w_state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (i_tx_busy) begin
          w_state_next = ST_WAIT_DONE;
        end else if (w_ack_to) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (w_next_byte) begin
          w_state_next = ST_START;
        end else if (w_release) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_tx_start  = 1'b0;
    o_req_ready = '0;
    o_busy      = (r_state != ST_IDLE);
    if (r_state == ST_START) begin
      o_tx_start  = 1'b1;
      o_req_ready = r_grant;
    end
  end

  assign o_grant   = r_grant;
  assign o_tx_data = r_tx_data;
  assign o_tx_err  = r_tx_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant   <= '0;
      r_gidx    <= '0;
      r_ptr     <= '0;
      r_count   <= '0;
      r_tx_data <= '0;
      r_su_cnt  <= '0;
      r_to_cnt  <= '0;
      r_tx_err  <= 1'b0;
    end else begin
      if (!w_started) begin
        r_su_cnt <= r_su_cnt + SU_W'(1);
      end

      if (w_launch) begin
        r_grant   <= w_pick_grant;
        r_gidx    <= w_pick_idx;
        r_count   <= w_pick_len;
        r_tx_data <= w_pick_data;
      end else if (w_next_byte) begin
        r_count   <= r_count - LEN_W'(1);
        r_tx_data <= w_cur_data;
      end else if (w_release) begin
        r_grant <= '0;
        r_ptr   <= w_ptr_next;
      end

      if (w_ack_to) begin
        r_tx_err <= 1'b1;
      end

      // Counted from the START cycle so the abort lands ACK_TIMEOUT cycles after tx_start.
      if ((r_state == ST_START) || (r_state == ST_WAIT_ACK)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ------------------------------------------------------------------
// tb_uart_tx_arbiter: directed tests for uart_tx_arbiter with a UART/requester model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_en;
  logic [1:0]  i_req_valid;
  logic [15:0] i_req_len;
  logic [15:0] i_req_data;
  logic [1:0]  o_req_ready;
  logic [1:0]  o_grant;
  logic        o_busy;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;
  logic        o_tx_err;

  int n_tests;
  int n_fail;

  int         n_start;
  logic [7:0] log_data [64];
  logic [1:0] log_grant [64];
  int         rdy_cnt [2];
  int         rq_len [2];
  logic [7:0] rq_base [2];
  int         rq_idx [2];
  int         rq_rep [2];
  int         rq_drop [2];
  bit         uart_on;
  int         busy_left;

  uart_tx_arbiter #(
    .NUM_REQ     (2),
    .LEN_W       (8),
    .STARTUP_CYC (16),
    .ACK_TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (i_en),
    .i_req_valid (i_req_valid),
    .i_req_len   (i_req_len),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .i_tx_busy   (i_tx_busy),
    .o_tx_err    (o_tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester k sends base, base+0x11, base+0x22, ... and drops valid after its last byte.
  task automatic model_update();
    if (o_tx_start) begin
      if (n_start < 64) begin
        log_data[n_start]  = o_tx_data;
        log_grant[n_start] = o_grant;
      end
      n_start++;
    end
    for (int i = 0; i < 2; i++) begin
      if (o_req_ready[i]) begin
        rdy_cnt[i]++;
        rq_idx[i]++;
        if (rq_idx[i] > rq_len[i]) begin
          if (rq_rep[i] > 0) begin
            rq_rep[i]--;
            rq_idx[i] = 0;
            i_req_data[i*8 +: 8] = rq_base[i];
          end else begin
            i_req_valid[i] = 1'b0;
          end
        end else begin
          i_req_data[i*8 +: 8] = rq_base[i] + 8'(rq_idx[i] * 17);
          if (rq_idx[i] == rq_drop[i]) i_req_valid[i] = 1'b0;
        end
      end
    end
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) i_tx_busy = 1'b0;
    end
    if (uart_on && o_tx_start) begin
      busy_left = 10;
      i_tx_busy = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic clear_logs();
    n_start    = 0;
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
  endtask

  task automatic start_pkt(input int i, input int len, input logic [7:0] base, input int rep);
    rq_len[i]            = len;
    rq_base[i]           = base;
    rq_idx[i]            = 0;
    rq_rep[i]            = rep;
    rq_drop[i]           = 0;
    i_req_len[i*8 +: 8]  = 8'(len);
    i_req_data[i*8 +: 8] = base;
    i_req_valid[i]       = 1'b1;
  endtask

  task automatic wait_idle(input logic [1:0] mask, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      step();
      if (!o_busy && ((i_req_valid & mask) == 2'b00) && !i_tx_busy) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles (busy=%b valid=%b), required idle", budget, o_busy, i_req_valid);
    end
  endtask

  task automatic wait_start(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      if (o_tx_start) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_start: no tx_start within %0d cycles, required one", budget);
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    i_en        = 1'b1;
    i_req_valid = 2'b00;
    i_req_len   = '0;
    i_req_data  = '0;
    i_tx_busy   = 1'b0;
    uart_on     = 1'b1;
    busy_left   = 0;
    for (int i = 0; i < 2; i++) begin
      rq_len[i] = 0; rq_base[i] = 8'h00; rq_idx[i] = 0; rq_rep[i] = 0; rq_drop[i] = 0;
    end
    clear_logs();
    step();
    step();
    n_tests++; if (o_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b required 00", o_grant); end
    n_tests++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b required 0", o_tx_start); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    n_tests++; if (o_tx_err !== 1'b0) begin n_fail++; $display("FAIL reset_tx_err: got %b required 0", o_tx_err); end
    n_tests++; if (o_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h required 00", o_tx_data); end
    n_tests++; if (o_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b required 00", o_req_ready); end
  endtask

  task automatic test_startup();
    int first_k;
    logic [1:0] grant_at16;
    first_k    = 0;
    grant_at16 = 2'bxx;
    clear_logs();
    start_pkt(0, 0, 8'h5A, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 16) grant_at16 = o_grant;
      if (o_tx_start && first_k == 0) first_k = k;
    end
    wait_idle(2'b11, 100);
    n_tests++; if (first_k != 17) begin n_fail++; $display("FAIL startup_first_start: got cycle %0d required 17", first_k); end
    n_tests++; if (grant_at16 !== 2'b00) begin n_fail++; $display("FAIL startup_grant_c16: got %b required 00", grant_at16); end
    n_tests++; if (n_start != 1 || log_data[0] !== 8'h5A) begin n_fail++; $display("FAIL startup_byte: got %0d starts data %h required 1 start data 5a", n_start, log_data[0]); end
  endtask

  task automatic test_single();
    logic [7:0] exp_data [3];
    exp_data[0] = 8'hA1; exp_data[1] = 8'hB2; exp_data[2] = 8'hC3;
    clear_logs();
    start_pkt(0, 2, 8'hA1, 0);
    wait_idle(2'b11, 300);
    n_tests++; if (n_start != 3) begin n_fail++; $display("FAIL single_starts: got %0d required 3", n_start); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (log_data[k] !== exp_data[k] || log_grant[k] !== 2'b01) begin
        n_fail++; $display("FAIL single_byte%0d: got data %h grant %b required data %h grant 01", k, log_data[k], log_grant[k], exp_data[k]);
      end
    end
    n_tests++; if (rdy_cnt[0] != 3 || rdy_cnt[1] != 0) begin n_fail++; $display("FAIL single_ready: got %0d/%0d required 3/0", rdy_cnt[0], rdy_cnt[1]); end
  endtask

  // Pointer sits at 1 after requester 0's last packet, so requester 1 goes first.
  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    logic [7:0] exp_d [4];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    exp_d[0] = 8'h20; exp_d[1] = 8'h10; exp_d[2] = 8'h20; exp_d[3] = 8'h10;
    clear_logs();
    start_pkt(0, 0, 8'h10, 1);
    start_pkt(1, 0, 8'h20, 1);
    wait_idle(2'b11, 600);
    n_tests++; if (n_start != 4) begin n_fail++; $display("FAIL rr_starts: got %0d required 4", n_start); end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (log_grant[k] !== exp_g[k] || log_data[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL rr_pkt%0d: got grant %b data %h required grant %b data %h", k, log_grant[k], log_data[k], exp_g[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_abort();
    clear_logs();
    start_pkt(1, 3, 8'h31, 0);
    rq_drop[1] = 2;
    wait_idle(2'b11, 300);
    n_tests++; if (n_start != 2) begin n_fail++; $display("FAIL abort_starts: got %0d required 2", n_start); end
    n_tests++;
    if (log_data[0] !== 8'h31 || log_data[1] !== 8'h42 || log_grant[1] !== 2'b10) begin
      n_fail++; $display("FAIL abort_bytes: got %h %h grant %b required 31 42 grant 10", log_data[0], log_data[1], log_grant[1]);
    end
    n_tests++; if (o_grant !== 2'b00 || o_tx_err !== 1'b0) begin n_fail++; $display("FAIL abort_release: got grant %b err %b required 00 0", o_grant, o_tx_err); end
  endtask

  task automatic test_en_block();
    bit extra;
    extra = 1'b0;
    clear_logs();
    start_pkt(0, 2, 8'hD1, 0);
    wait_start(30);
    i_en = 1'b0;
    start_pkt(1, 0, 8'h5C, 0);
    wait_idle(2'b01, 300);
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_tx_start || o_grant != 2'b00) extra = 1'b1;
    end
    n_tests++;
    if (n_start != 3 || log_data[0] !== 8'hD1 || log_data[1] !== 8'hE2 || log_data[2] !== 8'hF3 || log_grant[2] !== 2'b01) begin
      n_fail++; $display("FAIL en_packet_completes: got %0d starts %h %h %h required 3 starts d1 e2 f3", n_start, log_data[0], log_data[1], log_data[2]);
    end
    n_tests++; if (extra) begin n_fail++; $display("FAIL en_blocks_grant: got activity with en=0 required none"); end
    n_tests++; if (i_req_valid[1] !== 1'b1 || o_busy !== 1'b0) begin n_fail++; $display("FAIL en_held_request: got valid1 %b busy %b required 1 0", i_req_valid[1], o_busy); end
  endtask

  task automatic test_timeout();
    clear_logs();
    uart_on = 1'b0;
    start_pkt(0, 0, 8'h0E, 0);
    i_en = 1'b1;
    wait_start(10);
    n_tests++; if (o_grant !== 2'b10) begin n_fail++; $display("FAIL to_first_grant: got %b required 10", o_grant); end
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k == 63) begin
        n_tests++; if (o_tx_err !== 1'b0 || o_grant !== 2'b10) begin n_fail++; $display("FAIL to_early: got err %b grant %b required 0 10", o_tx_err, o_grant); end
      end
    end
    n_tests++; if (o_tx_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b required 1", o_tx_err); end
    n_tests++; if (o_grant !== 2'b00 || o_busy !== 1'b0) begin n_fail++; $display("FAIL to_release: got grant %b busy %b required 00 0", o_grant, o_busy); end
    uart_on = 1'b1;
    step();
    n_tests++;
    if (o_tx_start !== 1'b1 || o_grant !== 2'b01 || o_tx_data !== 8'h0E) begin
      n_fail++; $display("FAIL to_next_served: got start %b grant %b data %h required 1 01 0e", o_tx_start, o_grant, o_tx_data);
    end
    wait_idle(2'b11, 100);
    n_tests++; if (o_tx_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b required 1", o_tx_err); end
  endtask

  task automatic test_async_reset();
    int first_k;
    first_k = 0;
    clear_logs();
    start_pkt(0, 1, 8'h88, 0);
    wait_start(20);
    step(); step(); step();
    n_tests++; if (o_busy !== 1'b1 || i_tx_busy !== 1'b1 || o_tx_start !== 1'b0) begin n_fail++; $display("FAIL ar_in_wait_done: got busy %b tx_busy %b required 1 1", o_busy, i_tx_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_tx_start !== 1'b0 || o_grant !== 2'b00 || o_busy !== 1'b0 || o_tx_err !== 1'b0) begin
      n_fail++; $display("FAIL ar_immediate: got start %b grant %b busy %b err %b required 0 00 0 0", o_tx_start, o_grant, o_busy, o_tx_err);
    end
    step();
    clear_logs();
    start_pkt(0, 0, 8'h99, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (o_tx_start && first_k == 0) first_k = k;
    end
    n_tests++; if (first_k != 17) begin n_fail++; $display("FAIL ar_startup_again: got cycle %0d required 17", first_k); end
    n_tests++; if (n_start != 1 || log_data[0] !== 8'h99) begin n_fail++; $display("FAIL ar_after_reset: got %0d starts data %h required 1 data 99", n_start, log_data[0]); end
    wait_idle(2'b11, 100);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_startup();
    test_single();
    test_round_robin();
    test_abort();
    test_en_block();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
